// File: rtl/mcse_scan_guard.sv
// Key-authenticated scan access controller: per-chain unlock, failed-attempt
// lockout, and scrambled or zero data on locked chains.
module mcse_scan_guard #(
    parameter int unsigned N_CHAINS       = 4,
    parameter int unsigned KEY_WIDTH      = 64,
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1024,
    parameter int unsigned GARBAGE_MODE   = 1,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    localparam int unsigned AW            = $clog2(MAX_ATTEMPTS + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          scan_enable,
    input  logic                          lc_scan_allowed,
    input  logic [KEY_WIDTH-1:0]          key_in,
    input  logic                          key_valid,
    input  logic [3:0]                    chain_sel,
    input  logic [N_CHAINS*KEY_WIDTH-1:0] ref_keys,
    input  logic [N_CHAINS-1:0]           scan_in,
    output logic [N_CHAINS-1:0]           scan_out,
    output logic [N_CHAINS-1:0]           unlock_status,
    output logic                          key_ack,
    output logic                          key_err,
    output logic                          locked_out,
    output logic [AW-1:0]                 attempt_cnt
);

    localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);

    typedef enum logic [1:0] {READY, CHECK, LOCKOUT} state_t;

    state_t                state, state_d;
    logic [KEY_WIDTH-1:0]  key_q, key_d;
    logic [3:0]            sel_q, sel_d;
    logic [N_CHAINS-1:0]   unlock_d;
    logic                  ack_d, err_d, locked_d;
    logic [AW-1:0]         attempt_d, attempt_inc;
    logic [LW-1:0]         lock_cnt, lock_cnt_d;
    logic [15:0]           lfsr;
    logic                  se_q;
    logic                  relock;
    logic                  key_match;
    logic [N_CHAINS-1:0]   sel_mask;
    logic [N_CHAINS-1:0]   garbage;
    logic [N_CHAINS-1:0]   scan_out_d;

    // Out-of-range chain_sel yields an empty mask and therefore no match.
    always_comb begin
        key_match = 1'b0;
        sel_mask  = '0;
        for (int unsigned i = 0; i < N_CHAINS; i++) begin
            if (sel_q == 4'(i)) begin
                sel_mask[i] = 1'b1;
                if (key_q == ref_keys[i*KEY_WIDTH +: KEY_WIDTH]) key_match = 1'b1;
            end
        end
    end

    assign relock      = (se_q & ~scan_enable) | ~lc_scan_allowed;
    assign attempt_inc = attempt_cnt + AW'(1);

    always_comb begin
        state_d    = state;
        key_d      = key_q;
        sel_d      = sel_q;
        unlock_d   = unlock_status;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        locked_d   = locked_out;
        attempt_d  = attempt_cnt;
        lock_cnt_d = lock_cnt;
        case (state)
            READY: begin
                if (key_valid) begin
                    key_d   = key_in;
                    sel_d   = chain_sel;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                ack_d   = 1'b1;
                state_d = READY;
                if (!lc_scan_allowed) begin
                    err_d = 1'b1;
                end else if (key_match) begin
                    attempt_d = '0;
                    unlock_d  = unlock_status | sel_mask;
                end else begin
                    err_d     = 1'b1;
                    attempt_d = attempt_inc;
                    if (attempt_inc == AW'(MAX_ATTEMPTS)) begin
                        state_d    = LOCKOUT;
                        locked_d   = 1'b1;
                        unlock_d   = '0;
                        lock_cnt_d = LW'(LOCKOUT_CYCLES - 1);
                    end
                end
            end
            LOCKOUT: begin
                if (lock_cnt == '0) begin
                    state_d   = READY;
                    locked_d  = 1'b0;
                    attempt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt - LW'(1);
                end
            end
            default: state_d = READY;
        endcase
        // Relock overrides any unlock granted in the same cycle.
        if (relock) unlock_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= READY;
            key_q         <= '0;
            sel_q         <= '0;
            unlock_status <= '0;
            key_ack       <= 1'b0;
            key_err       <= 1'b0;
            locked_out    <= 1'b0;
            attempt_cnt   <= '0;
            lock_cnt      <= '0;
        end else begin
            state         <= state_d;
            key_q         <= key_d;
            sel_q         <= sel_d;
            unlock_status <= unlock_d;
            key_ack       <= ack_d;
            key_err       <= err_d;
            locked_out    <= locked_d;
            attempt_cnt   <= attempt_d;
            lock_cnt      <= lock_cnt_d;
        end
    end

    always_comb begin
        garbage = '0;
        for (int unsigned i = 0; i < N_CHAINS; i++) begin
            garbage[i] = (GARBAGE_MODE != 0) ? lfsr[i % 16] : 1'b0;
        end
        scan_out_d = scan_enable ? ((scan_in & unlock_status) | (garbage & ~unlock_status)) : '0;
    end

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr     <= LFSR_SEED;
            se_q     <= 1'b0;
            scan_out <= '0;
        end else begin
            se_q     <= scan_enable;
            scan_out <= scan_out_d;
            if (scan_enable) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

endmodule

// File: tb/tb_mcse_scan_guard.sv
// Randomized scoreboard bench for mcse_scan_guard with a cycle-level
// behavioural reference model.
module tb_mcse_scan_guard;

    localparam int N    = 4;
    localparam int KW   = 32;
    localparam int MAXA = 3;
    localparam int LOCK = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          scan_enable;
    logic          lc_scan_allowed;
    logic [KW-1:0] key_in;
    logic          key_valid;
    logic [3:0]    chain_sel;
    logic [N*KW-1:0] ref_keys;
    logic [N-1:0]  scan_in;
    logic [N-1:0]  scan_out;
    logic [N-1:0]  unlock_status;
    logic          key_ack;
    logic          key_err;
    logic          locked_out;
    logic [1:0]    attempt_cnt;

    mcse_scan_guard #(
        .N_CHAINS(N), .KEY_WIDTH(KW), .MAX_ATTEMPTS(MAXA),
        .LOCKOUT_CYCLES(LOCK), .GARBAGE_MODE(1), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .scan_enable(scan_enable),
        .lc_scan_allowed(lc_scan_allowed), .key_in(key_in), .key_valid(key_valid),
        .chain_sel(chain_sel), .ref_keys(ref_keys), .scan_in(scan_in),
        .scan_out(scan_out), .unlock_status(unlock_status), .key_ack(key_ack),
        .key_err(key_err), .locked_out(locked_out), .attempt_cnt(attempt_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [KW-1:0] ref_k [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining lockout cycles, a pending key, and plain sets of bits.
    logic [N-1:0]  m_unl;
    int            m_att;
    int            m_lock;
    logic          m_pend;
    logic [KW-1:0] m_key;
    int            m_sel;
    logic          m_pse;
    int unsigned   m_lfsr;
    logic [N-1:0]  m_so;
    logic          exp_q[$];

    task automatic model_reset();
        m_unl = '0; m_att = 0; m_lock = 0; m_pend = 0; m_key = '0; m_sel = 0;
        m_pse = 0; m_lfsr = 32'hACE1; m_so = '0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic relock;
        logic ok;
        int unsigned fb;
        relock = (m_pse && !scan_enable) || !lc_scan_allowed;
        m_so = '0;
        if (scan_enable)
            for (int i = 0; i < N; i++)
                m_so[i] = m_unl[i] ? scan_in[i] : 1'((m_lfsr >> i) & 1);
        if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_att = 0;
        end else if (m_pend) begin
            m_pend = 0;
            ok = 0;
            if (m_sel < N) ok = (m_key == ref_k[m_sel]);
            if (!lc_scan_allowed) begin
                exp_q.push_back(1'b1);
            end else if (ok) begin
                exp_q.push_back(1'b0);
                m_att = 0;
                m_unl[m_sel] = 1'b1;
            end else begin
                exp_q.push_back(1'b1);
                m_att++;
                if (m_att == MAXA) begin
                    m_lock = LOCK;
                    m_unl = '0;
                end
            end
        end else if (key_valid) begin
            m_pend = 1;
            m_key = key_in;
            m_sel = int'(chain_sel);
        end
        if (relock) m_unl = '0;
        if (scan_enable) begin
            fb = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
            m_lfsr = (m_lfsr >> 1) | (fb << 15);
        end
        m_pse = scan_enable;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Monitor: compares DUT outputs against the model every cycle and pops acks.
    int lk_run = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lk_run = 0;
            end else begin
                chk("unlock_status", 64'(unlock_status), 64'(m_unl));
                chk("attempt_cnt", 64'(attempt_cnt), 64'(m_att));
                chk("locked_out", 64'(locked_out), 64'(m_lock != 0));
                chk("scan_out", 64'(scan_out), 64'(m_so));
                chk("key_ack", 64'(key_ack), 64'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    if (key_ack) chk("key_err", 64'(key_err), 64'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
                if (locked_out) lk_run++;
                else if (lk_run != 0) begin
                    chk("lockout_len", 64'(lk_run), 64'(LOCK));
                    lk_run = 0;
                end
            end
        end
    end

    task automatic send(input int sel, input bit good);
        @(negedge clk);
        key_valid = 1'b1;
        chain_sel = 4'(sel);
        if (sel >= N) key_in = $urandom;
        else if (good) key_in = ref_k[sel];
        else key_in = ref_k[sel] ^ (32'h1 << $urandom_range(31, 0));
        @(negedge clk);
        key_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_scan_out"}, 64'(scan_out), 64'h0);
        chk({tag, "_unlock"}, 64'(unlock_status), 64'h0);
        chk({tag, "_attempt"}, 64'(attempt_cnt), 64'h0);
        chk({tag, "_locked"}, 64'(locked_out), 64'h0);
        chk({tag, "_ack"}, 64'(key_ack), 64'h0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            ref_k[i] = $urandom;
            ref_keys[i*KW +: KW] = ref_k[i];
        end
        rst_n = 1'b0; scan_enable = 1'b1; lc_scan_allowed = 1'b1;
        key_in = '0; key_valid = 1'b0; chain_sel = '0; scan_in = 4'hF;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        send(2, 1);
        repeat (2) @(negedge clk);
        chk("unlock_chain2", 64'(unlock_status), 64'h4);

        send(1, 0);
        send(1, 0);
        send(1, 0);
        send(0, 1);
        repeat (8) @(negedge clk);
        chk("post_lockout_attempt", 64'(attempt_cnt), 64'h0);
        chk("post_lockout_unlock", 64'(unlock_status), 64'h0);

        send(5, 1);
        chk("bad_sel_attempt", 64'(attempt_cnt), 64'h1);
        lc_scan_allowed = 1'b0;
        send(0, 1);
        lc_scan_allowed = 1'b1;
        chk("lc_block_attempt", 64'(attempt_cnt), 64'h1);

        send(0, 1);
        send(3, 1);
        chk("unlock_0_3", 64'(unlock_status), 64'h9);
        scan_enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("relock_unlock", 64'(unlock_status), 64'h0);
        chk("relock_scan_out", 64'(scan_out), 64'h0);
        repeat (5) @(negedge clk);
        scan_enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("reenable_locked", 64'(unlock_status), 64'h0);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            scan_enable     = ($urandom % 16) != 0;
            lc_scan_allowed = ($urandom % 20) != 0;
            scan_in         = 4'($urandom);
            key_valid       = ($urandom % 4) == 0;
            chain_sel       = 4'($urandom_range(5, 0));
            if (chain_sel >= 4'(N)) key_in = $urandom;
            else if ($urandom % 3 == 0) key_in = ref_k[chain_sel] ^ 32'h0100;
            else key_in = ref_k[chain_sel];
        end
        @(negedge clk);
        key_valid = 1'b0; scan_enable = 1'b1; lc_scan_allowed = 1'b1;

        repeat (12) @(negedge clk);
        send(1, 0);
        send(1, 0);
        send(1, 0);
        for (int i = 0; i < 60 && !locked_out; i++) @(negedge clk);
        chk("lockout_reached", 64'(locked_out), 64'h1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_lockout_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send(1, 1);
        repeat (2) @(negedge clk);
        chk("unlock_after_reset", 64'(unlock_status), 64'h2);

        repeat (20) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mcse_scan_guard.md
Name: mcse_scan_guard

Overview:
- Multi-chain, key-authenticated scan access controller for the MCSE security island.
- Gates N_CHAINS scan outputs independently. Each chain unlocks only after its own reference key is presented.
- Counts failed attempts and enforces a timed lockout. Drives scrambled or zero data on locked chains.
- Sits between the scan chain outputs and the chip scan pins. Keys come from the control unit; lifecycle gating comes from the LC controller.

Parameters:
- N_CHAINS, 4, number of independently protected scan chains (1..16).
- KEY_WIDTH, 64, width of each unlock key.
- MAX_ATTEMPTS, 3, consecutive failed attempts that trigger lockout (>=1).
- LOCKOUT_CYCLES, 1024, lockout duration in clk cycles (>=1).
- GARBAGE_MODE, 1, data on locked chains: 0 = constant 0, 1 = LFSR stream.
- LFSR_SEED, 16'hACE1, reset value of the 16-bit LFSR (must be nonzero).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- scan_enable  input  1  scan mode.
- lc_scan_allowed  input  1  lifecycle permits scan unlock.
- key_in  input  KEY_WIDTH  submitted key.
- key_valid  input  1  key submission strobe.
- chain_sel  input  4  target chain for the submitted key.
- ref_keys  input  N_CHAINS*KEY_WIDTH  reference keys; chain i occupies slice [i*KEY_WIDTH +: KEY_WIDTH].
- scan_in  input  N_CHAINS  raw scan chain data.
- scan_out  output  N_CHAINS  protected scan data.
- unlock_status  output  N_CHAINS  per-chain unlocked flag.
- key_ack  output  1  one-cycle result strobe.
- key_err  output  1  result qualifier, valid with key_ack; 1 = rejected.
- locked_out  output  1  lockout active.
- attempt_cnt  output  $clog2(MAX_ATTEMPTS+1)  consecutive failure count.

Behaviour:
- Reset values: all outputs 0; FSM in READY; LFSR = LFSR_SEED; lockout counter = 0.
- FSM states:
  - READY: accepts a key.
  - CHECK: compares the captured key.
  - LOCKOUT: ignores keys.
- READY:
  - key_valid=1 captures key_in and chain_sel.
  - Transition to CHECK.
- CHECK (one cycle): evaluates the captured key, then returns to READY or enters LOCKOUT. Latency: key_valid at cycle T gives key_ack=1 and updated status/attempt_cnt at T+2.
  - Accept: lc_scan_allowed=1, chain_sel<N_CHAINS, and key equals ref_keys slice for chain_sel. Then key_err=0, unlock_status[sel] set, attempt_cnt cleared.
  - Reject, lc_scan_allowed=0: key_err=1, attempt_cnt unchanged (not counted as an attempt).
  - Reject, otherwise (bad key or chain_sel>=N_CHAINS): key_err=1, attempt_cnt incremented.
  - If the increment makes attempt_cnt equal MAX_ATTEMPTS, enter LOCKOUT in the same cycle as the ack. Then locked_out=1, all unlock_status cleared, lockout counter loaded with LOCKOUT_CYCLES-1.
- key_valid while in CHECK or LOCKOUT: ignored, no ack.
- LOCKOUT:
  - Counter decrements each cycle.
  - When the counter reaches 0: return to READY, locked_out=0, attempt_cnt=0.
  - Total locked_out high time is exactly LOCKOUT_CYCLES cycles.
- Relock: the following clear all unlock_status bits on the next edge:
  - falling edge of scan_enable (registered previous value), or
  - lc_scan_allowed=0 at any time.
- Relock vs. success collision: relock wins. key_ack still pulses with key_err=0, but the bit stays 0 and attempt_cnt is still cleared.
- Re-keying an already-unlocked chain with the correct key: ack with key_err=0, no change.
- Re-keying with a wrong key: counts as a failure. The chain stays unlocked unless lockout fires.
- scan_out[i], registered, 1-cycle latency:
  - scan_enable & unlock_status[i]: scan_in[i].
  - scan_enable & ~unlock_status[i]: 0 when GARBAGE_MODE=0; LFSR bit (i mod 16) when GARBAGE_MODE=1.
  - ~scan_enable: 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances only while scan_enable=1; holds otherwise.
- Async reset mid-CHECK or mid-LOCKOUT: aborts, returns to reset values. Lockout is not persistent across reset.

Test Plan:
- Reset, scan_enable=1, no key, GARBAGE_MODE=0, scan_in=4'hF -> scan_out=0, unlock_status=0, attempt_cnt=0.
- Correct key to chain 2 at T, lc_scan_allowed=1 -> key_ack, key_err=0 at T+2; unlock_status=4'b0100; scan_out[2] follows scan_in[2] one cycle later; other chains 0 or LFSR.
- Three wrong keys, MAX_ATTEMPTS=3, LOCKOUT_CYCLES=8 -> attempt_cnt 1, 2, then locked_out=1 for exactly 8 cycles; unlock_status cleared; key_valid during lockout gives no ack; afterwards attempt_cnt=0.
- chain_sel=5 with N_CHAINS=4 -> key_err=1, attempt_cnt increments. lc_scan_allowed=0 with correct key -> key_err=1, attempt_cnt unchanged.
- Chains 0 and 3 unlocked, then scan_enable 1->0 -> unlock_status=0 next cycle; scan_out=0; re-enabling scan keeps the chains locked.
- GARBAGE_MODE=1, LFSR_SEED=16'hACE1, chain locked, scan_enable=1 -> scan_out[0] matches the reference LFSR bit-0 sequence starting from the seed; the sequence holds while scan_enable=0.
